// File: rtl/score_pkg.sv
// Shared encodings and sizes for the game-level score controller.
// Imported by the arbiter and the controller top.
package score_pkg;

  localparam int NUM_SCORE_REQ   = 4;
  localparam int ADD_SCORE_W     = 4;
  localparam int SCORE_WIDTH_DEC = 12;

  localparam logic [1:0] SCORE_ST_IDLE  = 2'd0;
  localparam logic [1:0] SCORE_ST_PLAY  = 2'd1;
  localparam logic [1:0] SCORE_ST_DRAIN = 2'd2;
  localparam logic [1:0] SCORE_ST_OVER  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_PLAY,
    ST_DRAIN,
    ST_OVER
  } score_st_e;

  // CLR is a one-cycle internal step and reports as IDLE
  function automatic logic [1:0] st_code(input score_st_e s);
    logic [1:0] c;
    c = SCORE_ST_IDLE;
    unique case (s)
      ST_PLAY:  c = SCORE_ST_PLAY;
      ST_DRAIN: c = SCORE_ST_DRAIN;
      ST_OVER:  c = SCORE_ST_OVER;
      default:  c = SCORE_ST_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/score_rr_arb.sv
// Round-robin candidate search: first valid source at or
// after the pointer, wrapping cyclically. Purely combinational.
module score_rr_arb
  import score_pkg::*;
#(
  parameter int NUM_REQ = NUM_SCORE_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [IDX_W-1:0] k;

  // Walk from farthest to nearest so the nearest hit wins
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    k       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (valid_i[k]) begin
        idx_o   = k;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_ctrl.sv
// Game-level score controller: arbitrates award requests into the
// BCD accumulator and sequences start / drain / high-score commit.
module score_ctrl
  import score_pkg::*;
#(
  parameter int NUM_REQ = NUM_SCORE_REQ,
  parameter int ADD_W   = ADD_SCORE_W,
  parameter int SCORE_W = SCORE_WIDTH_DEC
) (
  input  logic                     clk_vga,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*ADD_W-1:0] req_points_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     game_start_i,
  input  logic                     game_over_i,
  input  logic [SCORE_W-1:0]       score_i,
  output logic [ADD_W-1:0]         add_score_o,
  output logic                     score_clr_o,
  output logic [SCORE_W-1:0]       high_score_o,
  output logic                     new_record_o,
  output logic [1:0]               state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADD_W+1:0] ADD_MAX = {2'b00, {ADD_W{1'b1}}};

  score_st_e          st_q, st_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [ADD_W-1:0]   add_q, add_d;
  logic [ADD_W-1:0]   shadow_q, shadow_d;
  logic               clr_q, clr_d;
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic               nr_q, nr_d;

  logic [IDX_W-1:0]   cand_idx;
  logic               cand_found;
  logic [ADD_W-1:0]   cand_pts;
  logic [ADD_W+1:0]   fill_sum;
  logic               grant_en;

  score_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .idx_o   (cand_idx),
    .found_o (cand_found)
  );

  assign cand_pts = req_points_i[cand_idx*ADD_W +: ADD_W];

  // Buffer content plus the award in flight plus the candidate
  assign fill_sum = {2'b00, shadow_q} + {2'b00, add_q}
                  + {2'b00, cand_pts};

  assign grant_en = (st_q == ST_PLAY) && !game_start_i
                 && !game_over_i && cand_found
                 && (fill_sum <= ADD_MAX);

  assign req_ready_o  = grant_en ? (NUM_REQ'(1) << cand_idx) : '0;
  assign add_score_o  = add_q;
  assign score_clr_o  = clr_q;
  assign high_score_o = hs_q;
  assign new_record_o = nr_q;
  assign state_o      = st_code(st_q);

  always_comb begin
    st_d     = st_q;
    ptr_d    = ptr_q;
    add_d    = '0;
    hs_d     = hs_q;
    nr_d     = nr_q;
    shadow_d = (shadow_q != '0) ? shadow_q + add_q - ADD_W'(1)
                                : add_q;
    if (clr_q) shadow_d = '0;
    if (grant_en) begin
      add_d = cand_pts;
      ptr_d = IDX_W'((int'(cand_idx) + 1) % NUM_REQ);
    end
    unique case (st_q)
      ST_CLR: begin
        st_d = ST_PLAY;
        nr_d = 1'b0;
      end
      ST_IDLE, ST_OVER: begin
        if (game_start_i) st_d = ST_CLR;
      end
      ST_PLAY: begin
        if (game_start_i)     st_d = ST_CLR;
        else if (game_over_i) st_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (game_start_i) begin
          st_d = ST_CLR;
        end else if (shadow_q == '0 && add_q == '0) begin
          st_d = ST_OVER;
          if (score_i > hs_q) begin
            hs_d = score_i;
            nr_d = 1'b1;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
    clr_d = (st_d == ST_CLR);
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      ptr_q    <= '0;
      add_q    <= '0;
      shadow_q <= '0;
      clr_q    <= 1'b0;
      hs_q     <= '0;
      nr_q     <= 1'b0;
    end else begin
      st_q     <= st_d;
      ptr_q    <= ptr_d;
      add_q    <= add_d;
      shadow_q <= shadow_d;
      clr_q    <= clr_d;
      hs_q     <= hs_d;
      nr_q     <= nr_d;
    end
  end

endmodule
